// File: rtl/lab5_seq_ctrl.sv
// lab5_seq_ctrl: one-at-a-time sequencer around the lab5 classifier; define LAB5_SEQ_CMP_EN for expected-result compare
module lab5_seq_ctrl #(
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dut_in,
  input  logic              dut_a,
  input  logic              dut_b,
  input  logic              dut_c,
  input  logic              dut_d,
  output logic [3:0]        res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
`ifdef LAB5_SEQ_CMP_EN
  input  logic [3:0]        exp_data,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt,
`endif
  output logic [CNT_W-1:0]  proc_cnt
);
  localparam int SC_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam logic [7:0] CNT_INIT = 8'(SC_EFF - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, OUT = 2'd2} state_t;
  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_dut_in;
  logic [3:0]        r_res;
  logic              r_res_valid;
  logic [CNT_W-1:0]  r_proc;
  logic [3:0]        w_res;
`ifdef LAB5_SEQ_CMP_EN
  logic [3:0]        r_exp;
  logic              r_mis;
  logic [CNT_W-1:0]  r_err;
  assign mismatch = r_mis;
  assign err_cnt  = r_err;
`endif
  assign w_res     = {dut_a, dut_b, dut_c, dut_d};
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign dut_in    = r_dut_in;
  assign res_data  = r_res;
  assign res_valid = r_res_valid;
  assign proc_cnt  = r_proc;
  // accept a vector, let the classifier settle, capture its outputs, hold until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dut_in    <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_proc      <= '0;
`ifdef LAB5_SEQ_CMP_EN
      r_exp       <= '0;
      r_mis       <= 1'b0;
      r_err       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_dut_in <= in_data;
          r_cnt    <= CNT_INIT;
          r_state  <= SETTLE;
`ifdef LAB5_SEQ_CMP_EN
          r_exp    <= exp_data;
`endif
        end
        SETTLE: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        else begin
          r_res       <= w_res;
          r_res_valid <= 1'b1;
          r_state     <= OUT;
`ifdef LAB5_SEQ_CMP_EN
          r_mis       <= (w_res != r_exp);
          if (w_res != r_exp) r_err <= r_err + 1'b1;
`endif
        end
        OUT: if (r_res_valid && res_ready) begin
          r_res_valid <= 1'b0;
          r_proc      <= r_proc + 1'b1;
          r_state     <= IDLE;
`ifdef LAB5_SEQ_CMP_EN
          r_mis       <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lab5_seq_ctrl.sv
// tb_lab5_seq_ctrl: directed + random bench with a transaction-level model of the sequencer
module tb_lab5_seq_ctrl;
  localparam int SC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, busy, res_valid;
  logic [7:0] dut_in;
  logic dut_a = 1'b0, dut_b = 1'b0, dut_c = 1'b0, dut_d = 1'b0;
  logic [3:0] res_data;
  logic res_ready = 1'b0;
  logic [3:0] proc_cnt;
`ifdef LAB5_SEQ_CMP_EN
  logic [3:0] exp_data = '0;
  logic mismatch;
  logic [3:0] err_cnt;
  logic [3:0] m_exp = '0;
  logic m_mis = 1'b0;
  logic [3:0] m_err = '0;
`endif
  int checks = 0, passes = 0;
  int edge_n = 0, m_cap = 0;
  logic m_pend = 1'b0, m_valid = 1'b0;
  logic [7:0] m_dut_in = '0;
  logic [3:0] m_res = '0, m_proc = '0;

  lab5_seq_ctrl #(.DATA_W(8), .SETTLE_CYC(SC), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dut_in(dut_in), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
`ifdef LAB5_SEQ_CMP_EN
    .exp_data(exp_data), .mismatch(mismatch), .err_cnt(err_cnt),
`endif
    .proc_cnt(proc_cnt)
  );

  always #5 clk = ~clk;

  // stand-in classifier: a = at least four ones, b = odd parity, c = msb, d = all zero
  function automatic logic [3:0] classify(input logic [7:0] v);
    return {($countones(v) >= 4), ^v, v[7], (v == 8'h00)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
  endtask

  // transaction model: a vector is accepted when idle, its result appears SC edges later, and leaves on res_ready
  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0; m_valid = 1'b0; m_dut_in = '0; m_res = '0; m_proc = '0;
`ifdef LAB5_SEQ_CMP_EN
      m_mis = 1'b0; m_err = '0;
`endif
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend = 1'b1; m_dut_in = in_data; m_cap = edge_n + SC;
`ifdef LAB5_SEQ_CMP_EN
        m_exp = exp_data;
`endif
      end
    end else if (!m_valid) begin
      if (edge_n == m_cap) begin
        m_res = classify(m_dut_in); m_valid = 1'b1;
`ifdef LAB5_SEQ_CMP_EN
        m_mis = (m_res != m_exp);
        if (m_mis) m_err = m_err + 4'd1;
`endif
      end
    end else if (res_ready) begin
      m_valid = 1'b0; m_pend = 1'b0; m_proc = m_proc + 4'd1;
`ifdef LAB5_SEQ_CMP_EN
      m_mis = 1'b0;
`endif
    end
    edge_n++;
  end

  // classifier outputs are only honest right before the capture edge; garbage elsewhere must be ignored
  always @(negedge clk) begin
    {dut_a, dut_b, dut_c, dut_d} = (m_pend && !m_valid && edge_n == m_cap) ? classify(dut_in) : 4'($urandom);
  end

  // every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("in_ready", in_ready, !m_pend);
      check("busy", busy, m_pend);
      check("dut_in", dut_in, m_dut_in);
      check("res_valid", res_valid, m_valid);
      check("res_data", res_data, m_res);
      check("proc_cnt", proc_cnt, m_proc);
`ifdef LAB5_SEQ_CMP_EN
      check("mismatch", mismatch, m_mis);
      check("err_cnt", err_cnt, m_err);
`endif
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1); check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0); check("rst_dut_in", dut_in, 8'h00);
    check("rst_proc_cnt", proc_cnt, 0);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hF0; res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_dut_in", dut_in, 8'hF0); check("t2_busy", busy, 1);
    @(negedge clk);
    check("t2_not_yet", res_valid, 0);
    @(negedge clk);
    check("t2_res_valid", res_valid, 1); check("t2_res_data", res_data, 4'b1010);
    @(negedge clk);
    check("t2_done_valid", res_valid, 0); check("t2_proc_cnt", proc_cnt, 1);
    check("t2_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h33; res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_res_valid", res_valid, 1); check("t3_res_data", res_data, 4'b1000);
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_data", res_data, 4'b1000); check("t3_hold_ready", in_ready, 0);
      check("t3_hold_dut_in", dut_in, 8'h33);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("t3_hs_valid", res_valid, 0); check("t3_proc_cnt", proc_cnt, 2);
    check("t3_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_dut_in_55", dut_in, 8'h55); check("t3_busy", busy, 1);
    repeat (4) @(negedge clk);
    in_valid = 1'b1; in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", busy, 0); check("t4_dut_in", dut_in, 8'h00);
    check("t4_proc_cnt", proc_cnt, 0); check("t4_res_valid", res_valid, 0);
    repeat (4) @(negedge clk);
    in_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    check("t5_proc_15", proc_cnt, 15);
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    check("t5_proc_wrap", proc_cnt, 0);
    in_valid = 1'b0;
`ifdef LAB5_SEQ_CMP_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hF0; exp_data = 4'b1111; res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_mis_1", mismatch, 1); check("t6_err_1", err_cnt, 1);
    res_ready = 1'b1;
    @(negedge clk);
    check("t6_mis_clr", mismatch, 0);
    in_valid = 1'b1; exp_data = 4'b1010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_mis_0", mismatch, 0); check("t6_err_hold", err_cnt, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
`ifdef LAB5_SEQ_CMP_EN
      exp_data = 4'($urandom);
`endif
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
